// File: rtl/motor_drive_ctrl_pkg.sv
// Shared motor-drive definitions: state encoding, duty width, default timing
// and the saturating duty arithmetic used by the ramp.
package motor_drive_ctrl_pkg;

  localparam int PWM_W = 8;

  localparam logic [PWM_W-1:0] PWM_PERIOD_DEF = 8'd250;
  localparam logic [PWM_W-1:0] DUTY_MAX_DEF   = 8'd200;
  localparam logic [PWM_W-1:0] DUTY_STEP_DEF  = 8'd10;
  localparam logic [15:0]      RAMP_DIV_DEF   = 16'd1000;
  localparam logic [15:0]      DEAD_CYC_DEF   = 16'd5000;

  typedef enum logic [4:0] {
    ST_STOP      = 5'b00001,
    ST_RAMP_UP   = 5'b00010,
    ST_RUN       = 5'b00100,
    ST_RAMP_DOWN = 5'b01000,
    ST_DEAD      = 5'b10000
  } motor_state_e;

  // One extra bit of headroom so a step past the limit saturates instead of wrapping.
  function automatic logic [PWM_W-1:0] duty_inc(input logic [PWM_W-1:0] cur,
                                                input logic [PWM_W-1:0] step,
                                                input logic [PWM_W-1:0] lim);
    logic [PWM_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    return (sum >= {1'b0, lim}) ? lim : sum[PWM_W-1:0];
  endfunction

  function automatic logic [PWM_W-1:0] duty_dec(input logic [PWM_W-1:0] cur,
                                                input logic [PWM_W-1:0] step);
    logic [PWM_W:0] diff;
    diff = {1'b0, cur} - {1'b0, step};
    return diff[PWM_W] ? '0 : diff[PWM_W-1:0];
  endfunction

endpackage

// File: rtl/motor_drive_ctrl_pwm_gen.sv
// PWM generator: free-running period counter, duty shadow loaded at the wrap,
// registered compare output gated off while the bridge is braked.
module motor_drive_ctrl_pwm_gen
  import motor_drive_ctrl_pkg::*;
#(
  parameter logic [PWM_W-1:0] PWM_PERIOD = PWM_PERIOD_DEF
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic [PWM_W-1:0] duty,
  input  logic             brake,
  output logic             pwm_out
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_sh;

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      pwm_cnt <= '0;
      duty_sh <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (pwm_cnt == PWM_PERIOD - PWM_W'(1)) begin
        pwm_cnt <= '0;
        duty_sh <= duty;
      end else begin
        pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
      pwm_out <= (pwm_cnt < duty_sh) && !brake;
    end
  end

endmodule

// File: rtl/motor_drive_ctrl.sv
// Track-tilt motor sequencer: soft-start/stop duty ramp, braked dead time
// before any reversal, and the H-bridge PWM.
//
//   state        | meaning
//   ST_STOP      | braked, duty 0, waiting for enable
//   ST_RAMP_UP   | duty stepping up toward DUTY_MAX each ramp tick
//   ST_RUN       | full speed, at_speed high
//   ST_RAMP_DOWN | duty stepping down toward 0 each ramp tick
//   ST_DEAD      | braked hold of DEAD_CYC cycles, inputs ignored
module motor_drive_ctrl
  import motor_drive_ctrl_pkg::*;
#(
  parameter logic [PWM_W-1:0] PWM_PERIOD = PWM_PERIOD_DEF,
  parameter logic [PWM_W-1:0] DUTY_MAX   = DUTY_MAX_DEF,
  parameter logic [PWM_W-1:0] DUTY_STEP  = DUTY_STEP_DEF,
  parameter logic [15:0]      RAMP_DIV   = RAMP_DIV_DEF,
  parameter logic [15:0]      DEAD_CYC   = DEAD_CYC_DEF
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             enable,
  input  logic             direct,
  output logic             pwm_out,
  output logic             dir_out,
  output logic             brake,
  output logic [PWM_W-1:0] duty,
  output logic             at_speed,
  output logic             busy
);

  motor_state_e     state;
  logic [15:0]      presc;
  logic [15:0]      dead_cnt;
  logic             match;
  logic             ramping;
  logic             tick;
  logic [PWM_W-1:0] duty_up;
  logic [PWM_W-1:0] duty_dn;

  assign match   = enable && (direct == dir_out);
  assign ramping = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
  assign tick    = ramping && (presc == RAMP_DIV - 16'd1);
  assign duty_up = duty_inc(duty, DUTY_STEP, DUTY_MAX);
  assign duty_dn = duty_dec(duty, DUTY_STEP);

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state    <= ST_STOP;
      duty     <= '0;
      dir_out  <= 1'b0;
      brake    <= 1'b1;
      at_speed <= 1'b0;
      busy     <= 1'b0;
      presc    <= '0;
      dead_cnt <= '0;
    end else begin
      // Every transition below also clears presc so the first tick lands RAMP_DIV cycles in.
      presc <= (ramping && !tick) ? presc + 16'd1 : '0;
      case (state)
        ST_STOP: begin
          if (enable) begin
            state   <= ST_RAMP_UP;
            dir_out <= direct;
            brake   <= 1'b0;
            busy    <= 1'b1;
            presc   <= '0;
          end
        end
        ST_RAMP_UP: begin
          if (!match) begin
            state <= ST_RAMP_DOWN;
            presc <= '0;
          end else if (tick) begin
            duty <= duty_up;
            if (duty_up == DUTY_MAX) begin
              state    <= ST_RUN;
              at_speed <= 1'b1;
              presc    <= '0;
            end
          end
        end
        ST_RUN: begin
          if (!match) begin
            state    <= ST_RAMP_DOWN;
            at_speed <= 1'b0;
            presc    <= '0;
          end
        end
        ST_RAMP_DOWN: begin
          // A ramp-up aborted before its first tick arrives here already at 0.
          if (duty == '0) begin
            state    <= ST_DEAD;
            brake    <= 1'b1;
            dead_cnt <= DEAD_CYC - 16'd1;
            presc    <= '0;
          end else if (match) begin
            state <= ST_RAMP_UP;
            presc <= '0;
          end else if (tick) begin
            duty <= duty_dn;
            if (duty_dn == '0) begin
              state    <= ST_DEAD;
              brake    <= 1'b1;
              dead_cnt <= DEAD_CYC - 16'd1;
              presc    <= '0;
            end
          end
        end
        ST_DEAD: begin
          if (dead_cnt == '0) begin
            state <= ST_STOP;
            busy  <= 1'b0;
          end else begin
            dead_cnt <= dead_cnt - 16'd1;
          end
        end
        default: begin
          state    <= ST_STOP;
          duty     <= '0;
          brake    <= 1'b1;
          at_speed <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  motor_drive_ctrl_pwm_gen #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_pwm_gen (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .duty   (duty),
    .brake  (brake),
    .pwm_out(pwm_out)
  );

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl: directed scenarios plus random enable/direction
// segments, checked per cycle against a behavioural model through a queue.
module tb_motor_drive_ctrl;

  localparam int P_PERIOD = 10;
  localparam int P_MAX    = 8;
  localparam int P_STEP   = 3;
  localparam int P_DIV    = 4;
  localparam int P_DEAD   = 6;

  localparam int M_STOP = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;
  localparam int M_DEAD = 4;

  typedef struct packed {
    logic [7:0] duty;
    logic       pwm;
    logic       dir;
    logic       brake;
    logic       at_speed;
    logic       busy;
  } obs_t;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       direct = 1'b0;
  logic       pwm_out;
  logic       dir_out;
  logic       brake;
  logic [7:0] duty;
  logic       at_speed;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  obs_t exp_q[$];

  int m_mode = M_STOP;
  int m_age = 0;
  int m_duty = 0;
  int m_dir = 0;
  int m_pcnt = 0;
  int m_sh = 0;
  bit m_pwm = 1'b0;

  always #5 sclk = ~sclk;

  motor_drive_ctrl #(
    .PWM_PERIOD(8'd10),
    .DUTY_MAX  (8'd8),
    .DUTY_STEP (8'd3),
    .RAMP_DIV  (16'd4),
    .DEAD_CYC  (16'd6)
  ) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .enable  (enable),
    .direct  (direct),
    .pwm_out (pwm_out),
    .dir_out (dir_out),
    .brake   (brake),
    .duty    (duty),
    .at_speed(at_speed),
    .busy    (busy)
  );

  // Behavioural reference: advances one clock edge given the inputs held at that edge.
  task automatic model_step(input bit r, input bit e, input bit d);
    bit braked;
    bit match;
    bit tick;
    int nmode;
    braked = (m_mode == M_STOP) || (m_mode == M_DEAD);
    if (!r) begin
      m_mode = M_STOP; m_age = 0; m_duty = 0; m_dir = 0;
      m_pcnt = 0; m_sh = 0; m_pwm = 1'b0;
      return;
    end
    m_pwm = (m_pcnt < m_sh) && !braked;
    if (m_pcnt == P_PERIOD - 1) begin
      m_pcnt = 0;
      m_sh = m_duty;
    end else begin
      m_pcnt++;
    end
    match = e && (int'(d) == m_dir);
    tick = ((m_mode == M_UP) || (m_mode == M_DOWN)) && ((m_age % P_DIV) == P_DIV - 1);
    nmode = m_mode;
    case (m_mode)
      M_STOP: if (e) begin m_dir = int'(d); nmode = M_UP; end
      M_UP: begin
        if (!match) nmode = M_DOWN;
        else if (tick) begin
          m_duty = (m_duty + P_STEP > P_MAX) ? P_MAX : m_duty + P_STEP;
          if (m_duty == P_MAX) nmode = M_RUN;
        end
      end
      M_RUN: if (!match) nmode = M_DOWN;
      M_DOWN: begin
        if (m_duty == 0) nmode = M_DEAD;
        else if (match) nmode = M_UP;
        else if (tick) begin
          m_duty = (m_duty < P_STEP) ? 0 : m_duty - P_STEP;
          if (m_duty == 0) nmode = M_DEAD;
        end
      end
      default: if (m_age == P_DEAD - 1) nmode = M_STOP;
    endcase
    if (nmode != m_mode) begin
      m_mode = nmode;
      m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit d, input int n);
    obs_t x;
    repeat (n) begin
      @(negedge sclk);
      s_rst_n = r;
      enable = e;
      direct = d;
      model_step(r, e, d);
      x.duty = 8'(m_duty);
      x.pwm = m_pwm;
      x.dir = m_dir[0];
      x.brake = (m_mode == M_STOP) || (m_mode == M_DEAD);
      x.at_speed = (m_mode == M_RUN);
      x.busy = (m_mode != M_STOP);
      exp_q.push_back(x);
    end
  endtask

  // Monitor: every output sample after an edge that had stimulus is checked.
  initial begin
    obs_t act;
    obs_t exp_v;
    logic prev_dir;
    bit prev_ok;
    prev_ok = 1'b0;
    prev_dir = 1'b0;
    forever begin
      @(posedge sclk);
      #1;
      if (exp_q.size() > 0) begin
        cyc++;
        exp_v = exp_q.pop_front();
        act = '{duty: duty, pwm: pwm_out, dir: dir_out, brake: brake,
                at_speed: at_speed, busy: busy};
        n_vec++;
        if (act !== exp_v) begin
          n_err++;
          $display("FAIL outputs cycle %0d: actual duty=%0d pwm=%b dir=%b brake=%b at_speed=%b busy=%b, expected duty=%0d pwm=%b dir=%b brake=%b at_speed=%b busy=%b",
                   cyc, act.duty, act.pwm, act.dir, act.brake, act.at_speed, act.busy,
                   exp_v.duty, exp_v.pwm, exp_v.dir, exp_v.brake, exp_v.at_speed, exp_v.busy);
        end
        if (prev_ok && (dir_out !== prev_dir)) begin
          n_vec++;
          if (pwm_out !== 1'b0) begin
            n_err++;
            $display("FAIL dir_toggle_pwm cycle %0d: pwm_out=%b, expected 0", cyc, pwm_out);
          end
        end
        prev_dir = dir_out;
        prev_ok = 1'b1;
      end
    end
  end

  initial begin
    drive(0, 0, 0, 3);
    // soft start, soft stop
    drive(1, 1, 1, 20);
    drive(1, 0, 0, 25);
    // reversal from RUN
    drive(1, 1, 1, 20);
    drive(1, 1, 0, 45);
    // resume from RAMP_DOWN at duty 5
    drive(1, 0, 0, 5);
    drive(1, 1, 0, 12);
    // reset mid ramp-up at duty 6
    drive(1, 0, 0, 25);
    drive(1, 1, 1, 10);
    drive(0, 1, 1, 2);
    drive(1, 0, 1, 3);
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), $urandom_range(1, 30));
    end
    @(posedge sclk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
